// File: rtl/cond_unit_if.sv
// Execute-stage condition unit bus: decoder/ALU controls in, gated enables,
// flags, writeback registers and performance counters out.
interface cond_unit_if #(parameter int CNT_W = 32);
  logic             ex_valid;
  logic             stall;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             clr_cnt;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic [3:0]       Flags;
  logic             wb_valid;
  logic             wb_RegWrite;
  logic             wb_CondEx;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] skip_cnt;

  // Pipeline side driving the execute stage
  modport master (
    output ex_valid, stall, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, clr_cnt,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags, wb_valid, wb_RegWrite, wb_CondEx,
           exec_cnt, skip_cnt
  );

  // Condition unit itself
  modport slave (
    input  ex_valid, stall, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, clr_cnt,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags, wb_valid, wb_RegWrite, wb_CondEx,
           exec_cnt, skip_cnt
  );
endinterface

// File: rtl/cond_unit.sv
// ARM execute-stage condition unit: holds the NZCV flags register, evaluates
// the condition field against it, gates PC/register/memory write enables,
// registers the gated result for writeback and counts executed/skipped ops.
module cond_unit #(
  parameter int CNT_W = 32
) (
  input logic         clk,
  input logic         reset,
  cond_unit_if.slave  bus
);

  logic [3:0]       flags_p1;
  logic             cond_ex_p0;
  logic             fire_p0;
  logic             pc_src_p0;
  logic             reg_write_p0;
  logic             mem_write_p0;
  logic             wb_valid_p1;
  logic             wb_reg_write_p1;
  logic             wb_cond_ex_p1;
  logic [CNT_W-1:0] exec_cnt_p1;
  logic [CNT_W-1:0] skip_cnt_p1;

  // Condition check against the architectural flags {N,Z,C,V}.
  function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic pass;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = ~z & (n == v);
      4'b1101: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
    return pass;
  endfunction

  // ---- stage p0: execute (combinational condition and gated enables) ----

  // Condition is evaluated on the stored flags only; there is no ALU bypass.
  always_comb begin
    cond_ex_p0   = eval_cond(bus.Cond, flags_p1);
    fire_p0      = bus.ex_valid & ~bus.stall;
    pc_src_p0    = bus.PCS & cond_ex_p0 & fire_p0;
    reg_write_p0 = bus.RegW & ~bus.NoWrite & cond_ex_p0 & fire_p0;
    mem_write_p0 = bus.MemW & cond_ex_p0 & fire_p0;
  end

  // ---- stage p1: registered state (flags, writeback, counters) ----

  // Flags update only for an executed instruction; each pair is independent.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_p1 <= 4'b0000;
    end else if (fire_p0 && cond_ex_p0) begin
      if (bus.FlagW[1]) flags_p1[3:2] <= bus.ALUFlags[3:2];
      if (bus.FlagW[0]) flags_p1[1:0] <= bus.ALUFlags[1:0];
    end
  end

  // Writeback registers advance whenever the pipeline is not held.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_p1     <= 1'b0;
      wb_reg_write_p1 <= 1'b0;
      wb_cond_ex_p1   <= 1'b0;
    end else if (!bus.stall) begin
      wb_valid_p1     <= bus.ex_valid;
      wb_reg_write_p1 <= reg_write_p0;
      wb_cond_ex_p1   <= cond_ex_p0 & bus.ex_valid;
    end
  end

  // Performance counters wrap freely; a clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (reset || bus.clr_cnt) begin
      exec_cnt_p1 <= '0;
      skip_cnt_p1 <= '0;
    end else if (fire_p0) begin
      if (cond_ex_p0) exec_cnt_p1 <= exec_cnt_p1 + CNT_W'(1);
      else            skip_cnt_p1 <= skip_cnt_p1 + CNT_W'(1);
    end
  end

  assign bus.CondEx      = cond_ex_p0;
  assign bus.PCSrc       = pc_src_p0;
  assign bus.RegWrite    = reg_write_p0;
  assign bus.MemWrite    = mem_write_p0;
  assign bus.Flags       = flags_p1;
  assign bus.wb_valid    = wb_valid_p1;
  assign bus.wb_RegWrite = wb_reg_write_p1;
  assign bus.wb_CondEx   = wb_cond_ex_p1;
  assign bus.exec_cnt    = exec_cnt_p1;
  assign bus.skip_cnt    = skip_cnt_p1;

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_cond_unit;
  localparam int CW = 4;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  cond_unit_if #(.CNT_W(CW)) bus ();

  cond_unit #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Comparison helper shared by the model compare and the literal checks.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference condition: conditions come in pairs, odd code = negation of even.
  function automatic logic model_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: return 1'b1;
    endcase
    return base ^ cond[0];
  endfunction

  // Behavioural model state
  logic [3:0] m_flags;
  logic       m_wb_valid, m_wb_rw, m_wb_cex;
  int         m_exec, m_skip;
  logic       model_ok;
  logic       m_cex, m_fire;

  initial model_ok = 1'b0;

  assign m_cex  = model_cond(bus.Cond, m_flags);
  assign m_fire = bus.ex_valid & ~bus.stall;

  // Model update on each rising edge
  always @(posedge clk) begin
    if (reset) begin
      model_ok   <= 1'b1;
      m_flags    <= 4'b0000;
      m_wb_valid <= 1'b0;
      m_wb_rw    <= 1'b0;
      m_wb_cex   <= 1'b0;
      m_exec     <= 0;
      m_skip     <= 0;
    end else begin
      if (m_fire && m_cex) begin
        if (bus.FlagW[1]) m_flags[3:2] <= bus.ALUFlags[3:2];
        if (bus.FlagW[0]) m_flags[1:0] <= bus.ALUFlags[1:0];
      end
      if (!bus.stall) begin
        m_wb_valid <= bus.ex_valid;
        m_wb_cex   <= m_cex & bus.ex_valid;
        m_wb_rw    <= bus.RegW & ~bus.NoWrite & m_cex & m_fire;
      end
      if (bus.clr_cnt) begin
        m_exec <= 0;
        m_skip <= 0;
      end else if (m_fire) begin
        if (m_cex) m_exec <= (m_exec + 1) % (1 << CW);
        else       m_skip <= (m_skip + 1) % (1 << CW);
      end
    end
  end

  // Compare DUT outputs with the model on every falling edge
  always @(negedge clk) begin
    if (model_ok) begin
      check("CondEx",      32'(bus.CondEx),      32'(m_cex));
      check("PCSrc",       32'(bus.PCSrc),       32'(bus.PCS & m_cex & m_fire));
      check("RegWrite",    32'(bus.RegWrite),    32'(bus.RegW & ~bus.NoWrite & m_cex & m_fire));
      check("MemWrite",    32'(bus.MemWrite),    32'(bus.MemW & m_cex & m_fire));
      check("Flags",       32'(bus.Flags),       32'(m_flags));
      check("wb_valid",    32'(bus.wb_valid),    32'(m_wb_valid));
      check("wb_RegWrite", 32'(bus.wb_RegWrite), 32'(m_wb_rw));
      check("wb_CondEx",   32'(bus.wb_CondEx),   32'(m_wb_cex));
      check("exec_cnt",    32'(bus.exec_cnt),    32'(m_exec));
      check("skip_cnt",    32'(bus.skip_cnt),    32'(m_skip));
    end
  end

  // One cycle: apply inputs after the rising edge, return just after the falling edge.
  task automatic cyc(input logic rst, input logic ev, input logic st, input logic [3:0] cond,
                     input logic [3:0] alu, input logic [1:0] fw, input logic pcs,
                     input logic regw, input logic memw, input logic nw, input logic clr);
    @(posedge clk);
    #1;
    reset        = rst;
    bus.ex_valid = ev;
    bus.stall    = st;
    bus.Cond     = cond;
    bus.ALUFlags = alu;
    bus.FlagW    = fw;
    bus.PCS      = pcs;
    bus.RegW     = regw;
    bus.MemW     = memw;
    bus.NoWrite  = nw;
    bus.clr_cnt  = clr;
    @(negedge clk);
    #1;
  endtask

  // Bubble with a chosen condition code
  task automatic idle(input logic [3:0] cond);
    cyc(1'b0, 1'b0, 1'b0, cond, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Executed AL instruction that loads all four flags
  task automatic set_flags(input logic [3:0] f);
    cyc(1'b0, 1'b1, 1'b0, 4'b1110, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    // Reset with a flag-setting instruction firing at the same time
    reset        = 1'b1;
    bus.ex_valid = 1'b1;
    bus.stall    = 1'b0;
    bus.Cond     = 4'b1110;
    bus.ALUFlags = 4'b1111;
    bus.FlagW    = 2'b11;
    bus.PCS      = 1'b0;
    bus.RegW     = 1'b1;
    bus.MemW     = 1'b0;
    bus.NoWrite  = 1'b0;
    bus.clr_cnt  = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_flags",    32'(bus.Flags),    32'h0);
    check("rst_exec",     32'(bus.exec_cnt), 32'h0);
    check("rst_skip",     32'(bus.skip_cnt), 32'h0);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'h0);
    check("rst_wb_rw",    32'(bus.wb_RegWrite), 32'h0);
    idle(4'b0000);
    check("post_rst_EQ", 32'(bus.CondEx), 32'h0);
    idle(4'b0001);
    check("post_rst_NE", 32'(bus.CondEx), 32'h1);

    // CMP (no register write) then BEQ on the freshly written flags
    cyc(1'b0, 1'b1, 1'b0, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("cmp_regwrite", 32'(bus.RegWrite), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("beq_flags", 32'(bus.Flags), 32'h4);
    check("beq_pcsrc", 32'(bus.PCSrc), 32'h1);
    idle(4'b1110);
    check("cmp_beq_exec", 32'(bus.exec_cnt), 32'h2);

    // Skipped flag setter leaves flags untouched
    cyc(1'b0, 1'b1, 1'b0, 4'b0001, 4'b0010, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("skip_condex", 32'(bus.CondEx), 32'h0);
    check("skip_regw",   32'(bus.RegWrite), 32'h0);
    idle(4'b1110);
    check("skip_flags", 32'(bus.Flags), 32'h4);
    check("skip_cnt1",  32'(bus.skip_cnt), 32'h1);

    // Full 16x16 condition sweep, compared by the model every cycle
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 16; c++) idle(4'(c));
    end
    set_flags(4'b1001);
    idle(4'b1010);
    check("spot_GE_1001", 32'(bus.CondEx), 32'h1);
    set_flags(4'b0010);
    idle(4'b1000);
    check("spot_HI_0010", 32'(bus.CondEx), 32'h1);
    set_flags(4'b0110);
    idle(4'b1000);
    check("spot_HI_0110", 32'(bus.CondEx), 32'h0);

    // Partial N,Z update then a 3-cycle stall with fire requested
    set_flags(4'b0001);
    cyc(1'b0, 1'b1, 1'b0, 4'b1110, 4'b1011, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4'b1110);
    check("partial_flags", 32'(bus.Flags), 32'h9);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 4'b1110, 4'b0000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("stall_flags", 32'(bus.Flags), 32'h9);
      check("stall_en", 32'({bus.PCSrc, bus.RegWrite, bus.MemWrite}), 32'h0);
      check("stall_wb_valid", 32'(bus.wb_valid), 32'h0);
    end

    // Counter wrap at CNT_W=4 and clear-beats-increment
    cyc(1'b0, 1'b0, 1'b0, 4'b1110, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++)
      cyc(1'b0, 1'b1, 1'b0, 4'b1110, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("wrap_before", 32'(bus.exec_cnt), 32'hF);
    idle(4'b1110);
    check("wrap_exec", 32'(bus.exec_cnt), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 4'b1110, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 4'b1110, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("clr_pending_exec", 32'(bus.exec_cnt), 32'h1);
    idle(4'b1110);
    check("clr_exec", 32'(bus.exec_cnt), 32'h0);
    check("clr_skip", 32'(bus.skip_cnt), 32'h0);

    // Randomized traffic, including occasional reset and counter clears
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
          4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
    end
    idle(4'b1110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
